pe_matrix_ctrl: RTL and testbench
=================================

// Module: pe_matrix_ctrl
// PURPOSE
//  Sequencer for the inter-prediction PE array: streams the 16x16 current MB, then every 16-row
//  search-window band column by column, asserting the array's shift enables.
//  Flags each cycle where the array's absolute-difference (AD) bus holds a full candidate.
//  Tags that cycle with the candidate motion vector (mv_x, mv_y).
//  Sits between the CPR/SPR pixel RAMs and pe_matrix; its outputs feed the SAD tree / min-select.
// PARAMETERS
//  MACRO_DIM   16  macroblock edge (PE array columns/rows)
//  SEARCH_DIM  48  search window edge; N = SEARCH_DIM-MACRO_DIM+1 candidates per axis
//  AD_LAT      1   cycles from en_spr to AD bus update in the PE array
// PORTS
//  clk        in   1                     clock, rising edge
//  rst        in   1                     async reset, active-high
//  start      in   1                     pulse: begin search for one MB (accepted only in IDLE)
//  stall      in   1                     downstream back-pressure: freeze read issue
//  busy       out  1                     high from accepted start until done
//  cpr_rd_en  out  1                     CPR RAM read strobe
//  cpr_col    out  $clog2(MACRO_DIM)     CPR column address
//  spr_rd_en  out  1                     SPR RAM read strobe
//  spr_row    out  $clog2(SEARCH_DIM)    SPR band top row (= candidate y)
//  spr_col    out  $clog2(SEARCH_DIM)    SPR column address
//  en_cpr     out  1                     to pe_matrix.en_cpr (cpr_rd_en delayed 1, RAM latency)
//  en_spr     out  1                     to pe_matrix.en_spr (spr_rd_en delayed 1)
//  ad_valid   out  1                     AD bus holds candidate (mv_x, mv_y)
//  mv_x       out  $clog2(N)             candidate x offset, valid with ad_valid
//  mv_y       out  $clog2(N)             candidate y offset, valid with ad_valid
//  done       out  1                     1-cycle pulse after the last ad_valid
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, delay pipes cleared. Reset mid-search discards the search
//    with no done pulse. After release the block waits for a new start.
//  - FSM states: IDLE -> LOAD_CPR -> SEARCH -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 -> LOAD_CPR, busy=1 from next cycle; start outside IDLE ignored.
//  - LOAD_CPR: cpr_rd_en=1, cpr_col 0..MACRO_DIM-1, one per non-stalled cycle; after the last -> SEARCH.
//  - SEARCH: spr_rd_en=1; for row y=0..N-1, spr_col 0..SEARCH_DIM-1; col wraps to 0 and y+1.
//    After y=N-1, col=SEARCH_DIM-1 -> DRAIN.
//  - Read tag for (y, col) with col >= MACRO_DIM-1: enters a 1+AD_LAT-cycle pipe. On exit,
//    ad_valid=1 with mv_y=y and mv_x=col-(MACRO_DIM-1).
//    Per band: SEARCH_DIM reads, N valids; total N*N valids.
//  - DRAIN: no reads; waits until the pipe is empty. DONE: done=1 for one cycle, busy=0 next cycle.
//  - stall=1: rd_en outputs 0 and counters/state hold. Reads already issued still produce
//    en_spr/en_cpr and ad_valid (pipe not frozen). stall in IDLE/DRAIN/DONE has no effect.
//  - start and stall in the same IDLE cycle: start accepted; first read waits for stall=0.
//  - en_cpr and en_spr may be high in the same cycle (last CPR column overlaps first SPR read).
//  - Nominal latency, no stalls: start to done = 1 + MACRO_DIM + N*SEARCH_DIM + 1 + AD_LAT + 1 cycles.
// CONFIGURATION
//  - PE_CTRL_ABORT_EN defined: extra input port abort (1 bit). abort=1 while busy -> next cycle
//    rd_en=0, FSM to DRAIN, pipe flushed without ad_valid.
//    done then pulses once, with additional output aborted=1 in the same cycle.
//  - PE_CTRL_ABORT_EN undefined: no abort/aborted ports; search always runs to completion.
// TESTING
//  - MACRO_DIM=4,SEARCH_DIM=8,AD_LAT=1, start once -> 25 ad_valid in (y,x) raster order
//    (0,0)..(4,4); done 1+4+40+3 cycles after start.
//  - Default params, start -> cpr_col 0..15 then spr_col 0..47 x33 rows; 1089 ad_valid; one done.
//  - stall=1 for 5 cycles mid-band (spr_col=20) -> no address skipped or repeated;
//    done delayed exactly 5 cycles.
//  - start pulsed again while busy -> ignored; same ad_valid count and single done.
//  - rst high during SEARCH -> all outputs 0 same cycle; no done; new start runs a clean full search.
//  - PE_CTRL_ABORT_EN: abort at row 2 -> no further ad_valid, done=1 and aborted=1 within 1+AD_LAT+2 cycles.

Source files
------------

// File: rtl/pe_matrix_ctrl.sv
// pe_matrix_ctrl: sequences CPR/SPR reads for the PE array and tags AD-valid cycles with the candidate MV; optional abort (PE_CTRL_ABORT_EN)
module pe_matrix_ctrl #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int AD_LAT     = 1,
  localparam int N  = SEARCH_DIM - MACRO_DIM + 1,
  localparam int CW = $clog2(MACRO_DIM),
  localparam int SW = $clog2(SEARCH_DIM),
  localparam int NW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
`ifdef PE_CTRL_ABORT_EN
  input  logic          abort,
  output logic          aborted,
`endif
  output logic          busy,
  output logic          cpr_rd_en,
  output logic [CW-1:0] cpr_col,
  output logic          spr_rd_en,
  output logic [SW-1:0] spr_row,
  output logic [SW-1:0] spr_col,
  output logic          en_cpr,
  output logic          en_spr,
  output logic          ad_valid,
  output logic [NW-1:0] mv_x,
  output logic [NW-1:0] mv_y,
  output logic          done
);
  localparam int L = 1 + AD_LAT;
  typedef enum logic [2:0] {IDLE, LOAD_CPR, SEARCH, DRAIN, DONE} st_e;
  st_e           st_q;
  logic          busy_q, done_q, en_cpr_q, en_spr_q, ab, last_c, last_r, tag_v;
  logic [CW-1:0] cpr_col_q;
  logic [SW-1:0] spr_row_q, spr_col_q;
  logic [L-1:0]  pv_q;
  logic [NW-1:0] px_q [L];
  logic [NW-1:0] py_q [L];
  logic [NW-1:0] tag_x, tag_y;
`ifdef PE_CTRL_ABORT_EN
  logic ab_q, aborted_q;
  assign ab      = abort && (st_q == LOAD_CPR || st_q == SEARCH || st_q == DRAIN);
  assign aborted = aborted_q;
`else
  assign ab = 1'b0;
`endif
  assign cpr_rd_en = st_q == LOAD_CPR && !stall;
  assign spr_rd_en = st_q == SEARCH && !stall;
  assign last_c    = spr_col_q == SW'(SEARCH_DIM - 1);
  assign last_r    = spr_row_q == SW'(N - 1);
  assign tag_v     = spr_rd_en && spr_col_q >= SW'(MACRO_DIM - 1);
  assign tag_x     = NW'(spr_col_q - SW'(MACRO_DIM - 1));
  assign tag_y     = NW'(spr_row_q);
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpr_col   = cpr_col_q;
  assign spr_row   = spr_row_q;
  assign spr_col   = spr_col_q;
  assign en_cpr    = en_cpr_q;
  assign en_spr    = en_spr_q;
  assign ad_valid  = pv_q[L-1];
  assign mv_x      = px_q[L-1];
  assign mv_y      = py_q[L-1];
  // Control FSM: CPR column walk, SPR band raster, then drain the AD tag pipe before signalling done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpr_col_q <= '0;
      spr_row_q <= '0;
      spr_col_q <= '0;
`ifdef PE_CTRL_ABORT_EN
      ab_q      <= 1'b0;
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef PE_CTRL_ABORT_EN
      aborted_q <= 1'b0;
      if (ab) ab_q <= 1'b1;
`endif
      if (ab) st_q <= DRAIN;
      else case (st_q)
        IDLE: if (start) begin
          st_q      <= LOAD_CPR;
          busy_q    <= 1'b1;
          cpr_col_q <= '0;
          spr_row_q <= '0;
          spr_col_q <= '0;
        end
        LOAD_CPR: if (!stall) begin
          cpr_col_q <= cpr_col_q == CW'(MACRO_DIM - 1) ? '0 : cpr_col_q + 1'b1;
          if (cpr_col_q == CW'(MACRO_DIM - 1)) st_q <= SEARCH;
        end
        SEARCH: if (!stall) begin
          spr_col_q <= last_c ? '0 : spr_col_q + 1'b1;
          if (last_c) spr_row_q <= last_r ? '0 : spr_row_q + 1'b1;
          if (last_c && last_r) st_q <= DRAIN;
        end
        DRAIN: if (!(|pv_q)) begin
          st_q   <= DONE;
          done_q <= 1'b1;
`ifdef PE_CTRL_ABORT_EN
          aborted_q <= ab_q;
`endif
        end
        DONE: begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
`ifdef PE_CTRL_ABORT_EN
          ab_q   <= 1'b0;
`endif
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  // RAM-latency enables and AD tag pipe; the pipe keeps flowing under stall, abort flushes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cpr_q <= 1'b0;
      en_spr_q <= 1'b0;
      pv_q     <= '0;
      for (int i = 0; i < L; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      en_cpr_q <= cpr_rd_en;
      en_spr_q <= spr_rd_en;
      pv_q[0]  <= tag_v && !ab;
      px_q[0]  <= tag_x;
      py_q[0]  <= tag_y;
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1] && !ab;
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_pe_matrix_ctrl.sv
// tb_pe_matrix_ctrl: directed vector table plus stall, restart, reset and abort sequences on a 4x4/8x8 configuration
module tb_pe_matrix_ctrl;
  localparam int M = 4, S = 8, A = 1, N = S - M + 1;
  localparam int LAT = 1 + M + N * S + 1 + A + 1;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
  logic       busy, cpr_rd_en, spr_rd_en, en_cpr, en_spr, ad_valid, done;
  logic [1:0] cpr_col;
  logic [2:0] spr_row, spr_col, mv_x, mv_y;
`ifdef PE_CTRL_ABORT_EN
  logic abort = 1'b0, aborted;
`endif
  pe_matrix_ctrl #(.MACRO_DIM(M), .SEARCH_DIM(S), .AD_LAT(A)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
`ifdef PE_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .cpr_rd_en(cpr_rd_en), .cpr_col(cpr_col),
    .spr_rd_en(spr_rd_en), .spr_row(spr_row), .spr_col(spr_col),
    .en_cpr(en_cpr), .en_spr(en_spr), .ad_valid(ad_valid),
    .mv_x(mv_x), .mv_y(mv_y), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit st, sl, bz, crd;
    int cc;
    bit srd;
    int sr, sc;
    bit ec, es, av;
    int mx;
    bit dn;
  } vec_t;
  vec_t tv [15];
  int nvec = 0, nerr = 0, cyc = 0, nvalid = 0, ndone = 0, done_cyc = -1, ex = 0, ey = 0;
  bit mon = 1'b0;
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Raster-order reference for every ad_valid, plus done counting and timing
  always @(negedge clk) if (mon) begin
    if (ad_valid) begin
      chk("mv_y", int'(mv_y), ey);
      chk("mv_x", int'(mv_x), ex);
      nvalid++;
      if (ex == N - 1) begin
        ex = 0;
        ey++;
      end else ex++;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    cyc++;
  end
  task automatic begin_run();
    cyc = 0; nvalid = 0; ndone = 0; done_cyc = -1; ex = 0; ey = 0; mon = 1'b1;
  endtask
  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    begin_run();
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic finish_run(input int exp_cyc);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", int'(i < 400), 1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, exp_cyc);
    chk("valid_count", nvalid, N * N);
  endtask
  task automatic wait_row(input int row, output bit ok);
    int i;
    for (i = 0; i < 200 && !(spr_rd_en && int'(spr_row) == row); i++) begin
      @(posedge clk); #1;
    end
    ok = i < 200;
  endtask
  initial begin
    bit ok;
    int got;
    #20000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bit ok;
    int got;
    tv[0]  = '{1,0, 0,0,0, 0,0,0, 0,0, 0,0,0};
    tv[1]  = '{0,0, 1,1,0, 0,0,0, 0,0, 0,0,0};
    tv[2]  = '{0,0, 1,1,1, 0,0,0, 1,0, 0,0,0};
    tv[3]  = '{1,0, 1,1,2, 0,0,0, 1,0, 0,0,0};
    tv[4]  = '{0,0, 1,1,3, 0,0,0, 1,0, 0,0,0};
    tv[5]  = '{0,0, 1,0,0, 1,0,0, 1,0, 0,0,0};
    tv[6]  = '{0,0, 1,0,0, 1,0,1, 0,1, 0,0,0};
    tv[7]  = '{0,0, 1,0,0, 1,0,2, 0,1, 0,0,0};
    tv[8]  = '{0,0, 1,0,0, 1,0,3, 0,1, 0,0,0};
    tv[9]  = '{0,0, 1,0,0, 1,0,4, 0,1, 0,0,0};
    tv[10] = '{0,0, 1,0,0, 1,0,5, 0,1, 1,0,0};
    tv[11] = '{0,1, 1,0,0, 0,0,6, 0,1, 1,1,0};
    tv[12] = '{0,0, 1,0,0, 1,0,6, 0,0, 1,2,0};
    tv[13] = '{0,0, 1,0,0, 1,0,7, 0,1, 0,0,0};
    tv[14] = '{0,0, 1,0,0, 1,1,0, 0,1, 1,3,0};
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cpr_rd_en", int'(cpr_rd_en), 0);
    chk("rst_spr_rd_en", int'(spr_rd_en), 0);
    chk("rst_en_spr", int'(en_spr), 0);
    chk("rst_ad_valid", int'(ad_valid), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin_run();
    for (int k = 0; k < 15; k++) begin
      start = tv[k].st;
      stall = tv[k].sl;
      @(negedge clk);
      chk($sformatf("v%0d_busy", k), int'(busy), int'(tv[k].bz));
      chk($sformatf("v%0d_cpr_rd_en", k), int'(cpr_rd_en), int'(tv[k].crd));
      chk($sformatf("v%0d_cpr_col", k), int'(cpr_col), tv[k].cc);
      chk($sformatf("v%0d_spr_rd_en", k), int'(spr_rd_en), int'(tv[k].srd));
      chk($sformatf("v%0d_spr_row", k), int'(spr_row), tv[k].sr);
      chk($sformatf("v%0d_spr_col", k), int'(spr_col), tv[k].sc);
      chk($sformatf("v%0d_en_cpr", k), int'(en_cpr), int'(tv[k].ec));
      chk($sformatf("v%0d_en_spr", k), int'(en_spr), int'(tv[k].es));
      chk($sformatf("v%0d_ad_valid", k), int'(ad_valid), int'(tv[k].av));
      if (tv[k].av) chk($sformatf("v%0d_mv_x", k), int'(mv_x), tv[k].mx);
      chk($sformatf("v%0d_done", k), int'(done), int'(tv[k].dn));
      @(posedge clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    finish_run(LAT + 1);
    start_run();
    for (int i = 0; i < 200 && !(spr_rd_en && spr_row == 3'd2 && spr_col == 3'd5); i++) begin
      @(posedge clk); #1;
    end
    chk("stall_point_reached", int'(spr_row == 3'd2 && spr_col == 3'd5), 1);
    stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rd_en", int'(spr_rd_en), 0);
      chk("stall_col_hold", int'(spr_col), 5);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("resume_rd_en", int'(spr_rd_en), 1);
    chk("resume_col", int'(spr_col), 5);
    finish_run(LAT + 5);
    start_run();
    wait_row(1, ok);
    chk("reset_point_reached", int'(ok), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_spr_rd_en", int'(spr_rd_en), 0);
    chk("arst_spr_row", int'(spr_row), 0);
    chk("arst_spr_col", int'(spr_col), 0);
    chk("arst_en_spr", int'(en_spr), 0);
    chk("arst_ad_valid", int'(ad_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("arst_no_done", ndone, 0);
    chk("arst_idle", int'(busy), 0);
    start_run();
    finish_run(LAT);
`ifdef PE_CTRL_ABORT_EN
    start_run();
    wait_row(2, ok);
    chk("abort_point_reached", int'(ok), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    got = 0;
    for (int i = 0; i < 1 + A + 2; i++) begin
      @(negedge clk);
      chk("abort_no_valid", int'(ad_valid), 0);
      if (done) begin
        got++;
        chk("aborted_flag", int'(aborted), 1);
      end
    end
    chk("abort_done_once", got, 1);
    repeat (3) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
